cpu_lsu_ctrl: RTL
=================

# cpu_lsu_ctrl

Load/store unit controller between the CPU execute stage and the data-memory port. It accepts one RV32I load or store request at a time and decodes funct3 into access size and signedness. It sequences a single-beat req/ack memory transaction with byte enables and lane-aligned write data, then returns lane-extracted, sign/zero-extended load data to writeback. Misaligned accesses, illegal funct3 and memory timeouts are reported as error responses.

## Interface
- `TIMEOUT`, default 15: max cycles `mem_req` is held without `mem_ack` before an error is returned (1..255).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request from execute stage.
- `req_ready`  out  1: controller idle, request accepted when `req_valid & req_ready`.
- `req_store`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I funct3 (SB/SH/SW; LB/LH/LW/LBU/LHU).
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store source register (low bits used).
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_err`  out  1: qualifies `rsp_valid`; misaligned, illegal funct3, or timeout.
- `rsp_rdata`  out  32: extended load data; 0 for stores and errors.
- `mem_req`  out  1: memory access request, held until ack or timeout.
- `mem_we`  out  1: write strobe.
- `mem_addr`  out  32: word address (`req_addr[31:2]`, low two bits 0).
- `mem_be`  out  4: byte enables.
- `mem_wdata`  out  32: lane-aligned write data.
- `mem_ack`  in  1: memory completion; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32: read word.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On accept, register the address, store flag, funct3 and wdata, and run the decode checks.
  - If legal and aligned, go to ACCESS. Otherwise go to RESP with the error flag set and no memory access.
- Legal funct3:
  - Store: 000, 001, 010.
  - Load: 000, 001, 010, 100, 101.
  - Anything else is illegal.
- Alignment:
  - Half (x01): `addr[0]` must be 0.
  - Word (010): `addr[1:0]` must be 00.
  - Byte: always aligned.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << addr[1:0]`.
  - Word: `4'b1111`.
  - Loads drive the same `mem_be`.
- Store data: byte replicated to all four lanes; half replicated to both halves; word passed through.
- ACCESS:
  - `mem_req`=1 with `mem_we`/`mem_addr`/`mem_be`/`mem_wdata` stable.
  - On `mem_ack`: capture `mem_rdata`, then go to RESP.
  - Counter increments each ACCESS cycle without ack. When it reaches `TIMEOUT`, drop `mem_req`, set the error flag and go to RESP.
  - Ack in the same cycle the counter reaches `TIMEOUT` counts as success.
- Load extraction:
  - Select byte `addr[1:0]` or half `addr[1]` from the captured word.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- RESP: `rsp_valid`=1 for exactly one cycle, then return to IDLE. `mem_ack` seen outside ACCESS is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0, except `req_ready`=1. FSM resets to IDLE, counter to 0.
- Accept at edge T → `mem_req` high from T+1.
- Ack sampled at edge T+1+k (k≥0) → `rsp_valid` in cycle T+2+k. Minimum accept-to-response is 2 cycles.
- Error from decode: `rsp_valid` in cycle T+1, `mem_req` never asserted.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles, then `rsp_valid`/`rsp_err` the next cycle.
- Back-to-back: `req_ready` returns high in the cycle after RESP. Throughput is at most one request per 3 cycles.
- Reset asserted mid-operation: outputs clear immediately (asynchronous); the transaction is dropped with no response.

## Structure
- Package `cpu_lsu_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), the FSM state enum, and the lane/byte-enable helper function.
- Sub-module `cpu_lsu_align`: purely combinational. Holds byte-enable generation, store lane replication and load extraction/extension. Verified standalone.
- Top module: FSM, request/response registers, timeout counter.

## Test plan
- SB at addr 0x1003, wdata 0x000000A5, ack after 2 cycles → `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_we`=1; `rsp_valid` with `rsp_err`=0, `rsp_rdata`=0.
- LB at 0x2001, `mem_rdata`=0x1234F678, immediate ack → `rsp_rdata`=0xFFFFFFF6. LBU same → 0x000000F6. LHU at 0x2002 → 0x00001234.
- LW at 0x3002 → error at T+1, `mem_req` never asserted. funct3=011 load → `rsp_err`=1.
- LW at 0x4000, no ack, `TIMEOUT`=15 → `mem_req` high 15 cycles, then `rsp_err`=1. Ack on the 15th cycle → success with data.
- Reset asserted during ACCESS → all outputs 0 and `req_ready`=1 after release; the next request completes normally.
- Back-to-back SW then LW with `req_valid` held → second request accepted the cycle after the first `rsp_valid`; responses in order, none lost.

Source files
------------

// File: rtl/cpu_lsu_pkg.sv
// Shared definitions for the load/store unit controller: funct3 codes,
// FSM state encoding and lane/byte-enable helpers.
package cpu_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Byte enables from access size (funct3[1:0]) and byte offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Stores allow B/H/W only; loads additionally allow BU/HU.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words a word-aligned one.
  function automatic logic f3_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module cpu_lsu_align
  import cpu_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign be_o = lane_be(funct3_i[1:0], addr_lo_i);

  // Replicate narrow store data so every enabled lane carries it.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   wdata_o = {4{wdata_i[7:0]}};
      2'b01:   wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  // Pick the addressed byte/half and extend it to 32 bits.
  always_comb begin
    case (addr_lo_i)
      2'd0:    rbyte = rdata_i[7:0];
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      default: rbyte = rdata_i[31:24];
    endcase
    rhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{rbyte[7]}}, rbyte};
      F3_BU:   rdata_o = {24'd0, rbyte};
      F3_H:    rdata_o = {{16{rhalf[15]}}, rhalf};
      F3_HU:   rdata_o = {16'd0, rhalf};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/cpu_lsu_ctrl.sv
// Load/store unit controller: accepts one request, runs a single-beat
// req/ack memory access with timeout and returns an (error) response.
module cpu_lsu_ctrl
  import cpu_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  lsu_state_e  state_q;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_ready_q, rsp_valid_q, rsp_err_q, mem_req_q, mem_we_q;
  logic [31:0] rsp_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        dec_ok;

  // While idle the lane logic decodes the incoming request; afterwards it
  // works on the captured request to extract load data on ack.
  assign al_f3  = (state_q == ST_IDLE) ? req_funct3_i    : f3_q;
  assign al_off = (state_q == ST_IDLE) ? req_addr_i[1:0] : off_q;
  assign dec_ok = f3_legal(req_store_i, req_funct3_i) &&
                  f3_aligned(req_funct3_i[1:0], req_addr_i[1:0]);
  assign cnt_d  = cnt_q + 8'd1;

  cpu_lsu_align u_align (
    .funct3_i  (al_f3),
    .addr_lo_i (al_off),
    .wdata_i   (req_wdata_i),
    .rdata_i   (mem_rdata_i),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  // Sequencing FSM with registered outputs and timeout counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      store_q     <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      cnt_q       <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            store_q     <= req_store_i;
            f3_q        <= req_funct3_i;
            off_q       <= req_addr_i[1:0];
            cnt_q       <= 8'd0;
            if (dec_ok) begin
              state_q     <= ST_ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_store_i;
              mem_addr_q  <= {req_addr_i[31:2], 2'b00};
              mem_be_q    <= al_be;
              mem_wdata_q <= al_wdata;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack_i) begin
            state_q     <= ST_RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= store_q ? 32'd0 : al_rdata;
          end else if (cnt_d == TO_CNT) begin
            state_q     <= ST_RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'd0;
            cnt_q       <= cnt_d;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
